// File: rtl/tdc_channel_cfg_pkg.sv
// -----------------------------------------------------------------------------
// TDCChannelCfgPackage
// Shared definitions for the TDC channel configuration stage:
//   - register-port address map
//   - bit positions inside the CTRL register
//   - position of the master enable inside the published word
//   - handshake FSM state type
//   - helper that builds the "implemented channels" mask for a channel count
// -----------------------------------------------------------------------------
package TDCChannelCfgPackage;

    // Register-port address map
    localparam logic [1:0] ADDR_CH_MASK  = 2'd0;
    localparam logic [1:0] ADDR_CTRL     = 2'd1;
    localparam logic [1:0] ADDR_PUB_MASK = 2'd2;
    localparam logic [1:0] ADDR_PUB_CTRL = 2'd3;

    // CTRL register bit indices
    localparam int MASTER = 0;
    localparam int COMMIT = 1;
    localparam int AUTO   = 2;

    // Master enable position inside activate_channels
    localparam int MASTER_BIT = 16;

    // Consumer handshake states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        GUARD = 2'd2
    } fsm_state_e;

    // One bit set per implemented channel; bits at or above count stay 0.
    function automatic logic [15:0] channel_limit_mask(input int count);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            m[i] = (i < count);
        end
        return m;
    endfunction

endpackage

// File: rtl/tdc_cfg_notify_fsm.sv
// -----------------------------------------------------------------------------
// tdc_cfg_notify_fsm
// Owns the published configuration word and the consumer handshake:
// applies commits (immediately in IDLE, deferred while ACK/GUARD), tracks
// channel_changed and produces the one-cycle read acknowledge.
//
// Ports:
//   clk              system clock
//   reset            asynchronous active-high reset
//   commit_req_i     a commit is requested this cycle
//   commit_value_i   staged value after this edge (includes same-cycle write)
//   staged_value_i   staged value currently held (used for deferred commits)
//   read_req_i       consumer read request (level)
//   published_o      published word {master, mask[15:0]}
//   channel_changed_o published word changed, not yet acknowledged
//   read_ack_o       one-cycle acknowledge; published_o valid this cycle
//   apply_o          a commit is applied at the coming edge
// -----------------------------------------------------------------------------
module tdc_cfg_notify_fsm
    import TDCChannelCfgPackage::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_req_i,
    input  logic [16:0] commit_value_i,
    input  logic [16:0] staged_value_i,
    input  logic        read_req_i,
    output logic [16:0] published_o,
    output logic        channel_changed_o,
    output logic        read_ack_o,
    output logic        apply_o
);

    fsm_state_e  state_q, state_d;
    logic        pending_q, pending_d;
    logic [16:0] published_q, published_d;
    logic        changed_q, changed_d;
    logic        read_ack_q;
    logic        apply;
    logic [16:0] apply_value;
    logic        set_changed;
    logic        enter_ack;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        published_d = published_q;
        changed_d   = changed_q;
        apply       = 1'b0;
        apply_value = staged_value_i;
        set_changed = 1'b0;
        enter_ack   = 1'b0;

        case (state_q)
            IDLE: begin
                // A fresh commit carries the same-cycle write data; a
                // deferred-only commit takes whatever staging holds now.
                apply       = commit_req_i | pending_q;
                apply_value = commit_req_i ? commit_value_i : staged_value_i;
                pending_d   = 1'b0;
                if (apply) begin
                    published_d = apply_value;
                end else if (read_req_i) begin
                    // Ack is held off while a commit lands so the consumer
                    // always latches the newest value.
                    state_d = ACK;
                end
            end
            ACK: begin
                pending_d = pending_q | commit_req_i;
                state_d   = GUARD;
            end
            GUARD: begin
                // Request ignored here: consumer may drop it one cycle late.
                pending_d = pending_q | commit_req_i;
                state_d   = IDLE;
            end
            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
        endcase

        set_changed = apply && (apply_value != published_q);
        enter_ack   = (state_q == IDLE) && (state_d == ACK);

        // Set has priority over the clear on ack entry.
        if (set_changed) begin
            changed_d = 1'b1;
        end else if (enter_ack) begin
            changed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            published_q <= '0;
            changed_q   <= 1'b0;
            read_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            published_q <= published_d;
            changed_q   <= changed_d;
            read_ack_q  <= (state_d == ACK);
        end
    end

    assign published_o       = published_q;
    assign channel_changed_o = changed_q;
    assign read_ack_o        = read_ack_q;
    assign apply_o           = apply;

endmodule

// File: rtl/tdc_channel_cfg.sv
// -----------------------------------------------------------------------------
// tdc_channel_cfg
// Configuration register stage in front of the TDC channel-enable block.
// Host writes a staged channel mask / master enable through a 2-bit-address
// register port; commits publish the staged value on activate_channels, and
// the consumer fetches it with a read_active_channel / read_ack handshake.
//
// Optional build macro:
//   TDC_CFG_COMMIT_CNT_EN  adds an 8-bit wrapping count of applied commits,
//                          readable at address 3 bits [15:8] (0 otherwise).
//
// Ports:
//   clk                  system clock
//   reset                asynchronous active-high reset
//   cfg_wr / cfg_rd      host write / read strobes (one cycle each)
//   cfg_addr             register address
//   cfg_wdata            write data
//   cfg_rdata            read data (held between reads)
//   cfg_rvalid           one-cycle read data valid
//   activate_channels    published {master, mask[15:0]}
//   channel_changed      published value changed, not yet acknowledged
//   read_active_channel  consumer request (level)
//   read_ack             one-cycle acknowledge
// -----------------------------------------------------------------------------
module tdc_channel_cfg
    import TDCChannelCfgPackage::*;
#(
    parameter int CHANNEL_COUNT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_wr,
    input  logic        cfg_rd,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    output logic        cfg_rvalid,
    output logic [16:0] activate_channels,
    output logic        channel_changed,
    input  logic        read_active_channel,
    output logic        read_ack
);

    localparam logic [15:0] CH_LIMIT = channel_limit_mask(CHANNEL_COUNT);

    logic [15:0] staged_mask_q, staged_mask_d;
    logic        staged_master_q, staged_master_d;
    logic        auto_commit_q, auto_commit_d;
    logic [15:0] cfg_rdata_q, cfg_rdata_d;
    logic        cfg_rvalid_q;

    logic        wr_mask;
    logic        wr_ctrl;
    logic        commit_req;
    logic        apply;
    logic [16:0] published;
    logic [7:0]  commit_cnt;

    assign wr_mask = cfg_wr && (cfg_addr == ADDR_CH_MASK);
    assign wr_ctrl = cfg_wr && (cfg_addr == ADDR_CTRL);

    always_comb begin
        staged_mask_d   = wr_mask ? (cfg_wdata & CH_LIMIT) : staged_mask_q;
        staged_master_d = wr_ctrl ? cfg_wdata[MASTER] : staged_master_q;
        auto_commit_d   = wr_ctrl ? cfg_wdata[AUTO]   : auto_commit_q;
    end

    // Auto-commit uses its pre-write value, so the write that turns it on
    // does not itself commit.
    assign commit_req = (wr_ctrl && cfg_wdata[COMMIT]) ||
                        (auto_commit_q && (wr_mask || wr_ctrl));

    tdc_cfg_notify_fsm u_notify (
        .clk               (clk),
        .reset             (reset),
        .commit_req_i      (commit_req),
        .commit_value_i    ({staged_master_d, staged_mask_d}),
        .staged_value_i    ({staged_master_q, staged_mask_q}),
        .read_req_i        (read_active_channel),
        .published_o       (published),
        .channel_changed_o (channel_changed),
        .read_ack_o        (read_ack),
        .apply_o           (apply)
    );

`ifdef TDC_CFG_COMMIT_CNT_EN
    logic [7:0] commit_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_cnt_q <= '0;
        end else if (apply) begin
            commit_cnt_q <= commit_cnt_q + 8'd1;
        end
    end

    assign commit_cnt = commit_cnt_q;
`else
    logic unused_apply;
    assign unused_apply = apply;
    assign commit_cnt   = 8'd0;
`endif

    always_comb begin
        cfg_rdata_d = cfg_rdata_q;
        if (cfg_rd) begin
            case (cfg_addr)
                ADDR_CH_MASK:  cfg_rdata_d = staged_mask_q;
                ADDR_CTRL:     cfg_rdata_d = {13'b0, auto_commit_q, 1'b0, staged_master_q};
                ADDR_PUB_MASK: cfg_rdata_d = published[15:0];
                default:       cfg_rdata_d = {commit_cnt, 7'b0, published[MASTER_BIT]};
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staged_mask_q   <= '0;
            staged_master_q <= 1'b0;
            auto_commit_q   <= 1'b0;
            cfg_rdata_q     <= '0;
            cfg_rvalid_q    <= 1'b0;
        end else begin
            staged_mask_q   <= staged_mask_d;
            staged_master_q <= staged_master_d;
            auto_commit_q   <= auto_commit_d;
            cfg_rdata_q     <= cfg_rdata_d;
            cfg_rvalid_q    <= cfg_rd;
        end
    end

    assign cfg_rdata         = cfg_rdata_q;
    assign cfg_rvalid        = cfg_rvalid_q;
    assign activate_channels = published;

endmodule

// File: tb/tb_tdc_channel_cfg.sv
// -----------------------------------------------------------------------------
// tb_tdc_channel_cfg
// Directed scenarios with literal expectations, then randomized traffic.
// A behavioural model (plain variables, updated once per clock edge) is
// compared against every DUT output on each falling edge.
// -----------------------------------------------------------------------------
module tb_tdc_channel_cfg;

    localparam int CH = 2;

    logic        clk;
    logic        reset;
    logic        cfg_wr;
    logic        cfg_rd;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        cfg_rvalid;
    logic [16:0] activate_channels;
    logic        channel_changed;
    logic        read_active_channel;
    logic        read_ack;

    tdc_channel_cfg #(.CHANNEL_COUNT(CH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cfg_wr              (cfg_wr),
        .cfg_rd              (cfg_rd),
        .cfg_addr            (cfg_addr),
        .cfg_wdata           (cfg_wdata),
        .cfg_rdata           (cfg_rdata),
        .cfg_rvalid          (cfg_rvalid),
        .activate_channels   (activate_channels),
        .channel_changed     (channel_changed),
        .read_active_channel (read_active_channel),
        .read_ack            (read_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 0;

    // Behavioural model state
    logic [15:0] m_mask;
    logic        m_master;
    logic        m_auto;
    logic [16:0] m_pub;
    logic        m_pend;
    logic        m_chg;
    int          m_busy;     // cycles left in the handshake; 2 = ack cycle
    logic [15:0] m_rdata;
    logic        m_rvalid;
    logic [7:0]  m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask = '0; m_master = 0; m_auto = 0; m_pub = '0; m_pend = 0;
        m_chg = 0; m_busy = 0; m_rdata = '0; m_rvalid = 0; m_cnt = '0;
    endtask

    task automatic model_step();
        logic [15:0] lim, nm;
        logic        nmas, nauto, wm, wc, creq, applied;
        logic [16:0] val;
        logic [7:0]  cnt_rd;
        lim   = (CH >= 16) ? 16'hFFFF : 16'((32'd1 << CH) - 1);
        wm    = cfg_wr && cfg_addr == 2'd0;
        wc    = cfg_wr && cfg_addr == 2'd1;
        nm    = wm ? (cfg_wdata & lim) : m_mask;
        nmas  = wc ? cfg_wdata[0] : m_master;
        nauto = wc ? cfg_wdata[2] : m_auto;
        creq  = (wc && cfg_wdata[1]) || (m_auto && (wm || wc));
`ifdef TDC_CFG_COMMIT_CNT_EN
        cnt_rd = m_cnt;
`else
        cnt_rd = 8'd0;
`endif
        if (cfg_rd) begin
            case (cfg_addr)
                2'd0: m_rdata = m_mask;
                2'd1: m_rdata = {13'b0, m_auto, 1'b0, m_master};
                2'd2: m_rdata = m_pub[15:0];
                default: m_rdata = {cnt_rd, 7'b0, m_pub[16]};
            endcase
        end
        m_rvalid = cfg_rd;
        if (m_busy == 0) begin
            applied = 0;
            val = '0;
            if (creq) begin
                val = {nmas, nm}; applied = 1;
            end else if (m_pend) begin
                val = {m_master, m_mask}; applied = 1;
            end
            m_pend = 0;
            if (applied) begin
                if (val != m_pub) m_chg = 1;
                m_pub = val;
                m_cnt = m_cnt + 8'd1;
            end else if (read_active_channel) begin
                m_busy = 2;
                m_chg  = 0;
            end
        end else begin
            if (creq) m_pend = 1;
            m_busy = m_busy - 1;
        end
        m_mask = nm; m_master = nmas; m_auto = nauto;
    endtask

    // One clock edge with the given inputs; returns 1 ns after the edge.
    task automatic tick(input logic w, input logic r, input logic [1:0] a,
                        input logic [15:0] d, input logic q);
        @(negedge clk);
        cfg_wr = w; cfg_rd = r; cfg_addr = a; cfg_wdata = d; read_active_channel = q;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cfg_wr = 0; cfg_rd = 0; cfg_addr = 0; cfg_wdata = 0; read_active_channel = 0;
        reset = 1;
        model_reset();
        @(posedge clk);
        #2 reset = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("activate_channels", 32'(activate_channels), 32'(m_pub));
            check("channel_changed", 32'(channel_changed), 32'(m_chg));
            check("read_ack", 32'(read_ack), 32'(m_busy == 2));
            check("cfg_rvalid", 32'(cfg_rvalid), 32'(m_rvalid));
            check("cfg_rdata", 32'(cfg_rdata), 32'(m_rdata));
        end
    end

    initial begin
        logic [7:0] exp_cnt;
        cfg_wr = 0; cfg_rd = 0; cfg_addr = 0; cfg_wdata = 0; read_active_channel = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 0;
        chk_en = 1;

        // Reset state, then a plain request is acknowledged with value 0
        check("rst_pub", 32'(activate_channels), 32'h0);
        check("rst_rvalid", 32'(cfg_rvalid), 32'h0);
        tick(0, 0, 0, 0, 1);
        check("first_ack", 32'(read_ack), 32'h1);
        check("first_ack_val", 32'(activate_channels), 32'h0);
        check("first_ack_chg", 32'(channel_changed), 32'h0);
        tick(0, 0, 0, 0, 0);
        check("ack_one_cycle", 32'(read_ack), 32'h0);
        tick(0, 0, 0, 0, 0);

        // Mask clamped to CHANNEL_COUNT bits; commit with master=1
        tick(1, 0, 2'd0, 16'hFFFF, 0);
        tick(1, 0, 2'd1, 16'h0003, 0);
        check("commit_pub", 32'(activate_channels), 32'h10003);
        check("commit_chg", 32'(channel_changed), 32'h1);
        tick(0, 1, 2'd0, 0, 0);
        check("rd_mask", 32'(cfg_rdata), 32'h0003);
        check("rd_rvalid", 32'(cfg_rvalid), 32'h1);
        tick(0, 0, 0, 0, 0);
        check("rvalid_drop", 32'(cfg_rvalid), 32'h0);

        // Ack clears channel_changed; request in GUARD is ignored
        tick(0, 0, 0, 0, 1);
        check("ack2", 32'(read_ack), 32'h1);
        check("ack2_chg_clr", 32'(channel_changed), 32'h0);
        tick(0, 0, 0, 0, 1);
        check("guard_no_ack", 32'(read_ack), 32'h0);
        tick(0, 0, 0, 0, 0);
        check("idle_no_ack", 32'(read_ack), 32'h0);

        // Commit written during ACK is deferred to the first IDLE cycle
        tick(1, 0, 2'd0, 16'h0002, 0);
        tick(0, 0, 0, 0, 1);
        check("ack3", 32'(read_ack), 32'h1);
        tick(1, 0, 2'd1, 16'h0003, 0);
        check("frozen_ack", 32'(activate_channels), 32'h10003);
        tick(0, 0, 0, 0, 0);
        check("frozen_guard", 32'(activate_channels), 32'h10003);
        tick(0, 0, 0, 0, 0);
        check("deferred_pub", 32'(activate_channels), 32'h10002);
        check("deferred_chg", 32'(channel_changed), 32'h1);

        // Auto-commit write coincident with a request: publish first, ack next
        tick(1, 0, 2'd1, 16'h0004, 0);
        check("auto_no_commit", 32'(activate_channels), 32'h10002);
        tick(1, 0, 2'd0, 16'h0001, 1);
        check("auto_pub", 32'(activate_channels), 32'h00001);
        check("auto_ack_deferred", 32'(read_ack), 32'h0);
        tick(0, 0, 0, 0, 1);
        check("auto_ack", 32'(read_ack), 32'h1);
        check("auto_ack_val", 32'(activate_channels), 32'h00001);

        // Reset in the ack cycle drops read_ack at once
        read_active_channel = 0;
        #2 reset = 1;
        model_reset();
        #1;
        check("rst_mid_ack", 32'(read_ack), 32'h0);
        check("rst_mid_pub", 32'(activate_channels), 32'h0);
        @(posedge clk);
        #2 reset = 0;

        // 257 commits then read the commit counter field
        do_reset();
        for (int i = 0; i < 257; i++) begin
            tick(1, 0, 2'd1, 16'h0002, 0);
        end
        tick(0, 1, 2'd3, 0, 0);
`ifdef TDC_CFG_COMMIT_CNT_EN
        exp_cnt = 8'h01;
`else
        exp_cnt = 8'h00;
`endif
        check("commit_cnt", 32'(cfg_rdata[15:8]), 32'(exp_cnt));

        // Randomized traffic checked cycle-by-cycle against the model
        for (int i = 0; i < 3000; i++) begin
            logic        w, r, q;
            logic [1:0]  a;
            logic [15:0] d;
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            a = 2'($urandom_range(0, 3));
            d = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 7));
            q = ($urandom_range(0, 2) != 0);
            tick(w, r, a, d, q);
        end
        tick(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
